// File: rtl/limit_irq_monitor.sv
// Per-channel debounced limit monitor with hysteresis, sticky trip flags and a masked irq.
// Optional stale-input watchdog enabled by defining LIMIT_STALE_WDT_EN.
module limit_irq_monitor #(
  parameter int CHN       = 2,
  parameter int TRIP_CNT  = 3,
  parameter int CLR_CNT   = 3,
  parameter int HYST      = 4,
  parameter int STALE_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CHN*8-1:0] value,
  input  logic [CHN-1:0]   value_update,
  input  logic [CHN*8-1:0] threshold,
  input  logic [CHN-1:0]   irq_mask,
  input  logic [CHN-1:0]   irq_clr,
  output logic [CHN-1:0]   over_limit,
  output logic [CHN-1:0]   irq_status,
  output logic [CHN-1:0]   stale,
  output logic             irq
);

  typedef enum logic [1:0] {NORMAL, PEND, TRIPPED, RECOV} state_t;

  localparam logic [3:0] TRIP_N = 4'(TRIP_CNT);
  localparam logic [3:0] CLR_N  = 4'(CLR_CNT);
  localparam logic [7:0] HYST_B = 8'(HYST);

  if (TRIP_CNT < 1 || TRIP_CNT > 15 || CLR_CNT < 1 || CLR_CNT > 15 || STALE_CYC < 1) begin : g_bad_param
    $error("limit_irq_monitor: parameter out of range");
  end

  state_t         state    [CHN];
  state_t         state_nx [CHN];
  logic [3:0]     cnt      [CHN];
  logic [3:0]     cnt_nx   [CHN];
  logic [CHN-1:0] trip_set;
  logic [CHN-1:0] stale_set;

  function automatic logic is_over(input logic [7:0] sample, input logic [7:0] thr);
    return sample > thr;
  endfunction

  // Recovery limit saturates at zero when the threshold is below the hysteresis
  function automatic logic is_rec(input logic [7:0] sample, input logic [7:0] thr);
    logic [7:0] lim;
    lim = (thr >= HYST_B) ? (thr - HYST_B) : 8'd0;
    return sample <= lim;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHN; i++) begin
        state[i] <= NORMAL;
        cnt[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < CHN; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
      end
    end
  end

  always_comb begin
    trip_set = '0;
    for (int i = 0; i < CHN; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      if (value_update[i]) begin
        case (state[i])
          NORMAL: begin
            if (is_over(value[i*8+:8], threshold[i*8+:8])) begin
              if (TRIP_N == 4'd1) begin
                state_nx[i] = TRIPPED;
                cnt_nx[i]   = 4'd0;
                trip_set[i] = 1'b1;
              end else begin
                state_nx[i] = PEND;
                cnt_nx[i]   = 4'd1;
              end
            end
          end
          PEND: begin
            if (is_over(value[i*8+:8], threshold[i*8+:8])) begin
              if (cnt[i] + 4'd1 == TRIP_N) begin
                state_nx[i] = TRIPPED;
                cnt_nx[i]   = 4'd0;
                trip_set[i] = 1'b1;
              end else begin
                cnt_nx[i] = cnt[i] + 4'd1;
              end
            end else begin
              state_nx[i] = NORMAL;
              cnt_nx[i]   = 4'd0;
            end
          end
          TRIPPED: begin
            if (is_rec(value[i*8+:8], threshold[i*8+:8])) begin
              if (CLR_N == 4'd1) begin
                state_nx[i] = NORMAL;
                cnt_nx[i]   = 4'd0;
              end else begin
                state_nx[i] = RECOV;
                cnt_nx[i]   = 4'd1;
              end
            end else begin
              cnt_nx[i] = 4'd0;
            end
          end
          RECOV: begin
            if (is_rec(value[i*8+:8], threshold[i*8+:8])) begin
              if (cnt[i] + 4'd1 == CLR_N) begin
                state_nx[i] = NORMAL;
                cnt_nx[i]   = 4'd0;
              end else begin
                cnt_nx[i] = cnt[i] + 4'd1;
              end
            end else begin
              state_nx[i] = TRIPPED;
              cnt_nx[i]   = 4'd0;
            end
          end
          default: begin
            state_nx[i] = NORMAL;
            cnt_nx[i]   = 4'd0;
          end
        endcase
      end
    end
  end

  always_comb begin
    over_limit = '0;
    for (int i = 0; i < CHN; i++) begin
      over_limit[i] = (state[i] == TRIPPED) || (state[i] == RECOV);
    end
  end

`ifdef LIMIT_STALE_WDT_EN
  localparam int             WW   = $clog2(STALE_CYC + 1);
  localparam logic [WW-1:0] WMAX = WW'(STALE_CYC);

  logic [WW-1:0] wdt [CHN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHN; i++) wdt[i] <= '0;
    end else begin
      for (int i = 0; i < CHN; i++) begin
        if (value_update[i])  wdt[i] <= '0;
        else if (wdt[i] != WMAX) wdt[i] <= wdt[i] + 1'b1;
      end
    end
  end

  // The set fires only on the step into saturation, so once per stale episode
  always_comb begin
    stale     = '0;
    stale_set = '0;
    for (int i = 0; i < CHN; i++) begin
      stale[i]     = (wdt[i] == WMAX);
      stale_set[i] = !value_update[i] && (wdt[i] == WMAX - 1'b1);
    end
  end
`else
  assign stale     = '0;
  assign stale_set = '0;
`endif

  // Set wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_status <= '0;
      irq        <= 1'b0;
    end else begin
      irq_status <= (irq_status & ~irq_clr) | trip_set | stale_set;
      irq        <= |(irq_status & ~irq_mask);
    end
  end

endmodule

// File: doc/limit_irq_monitor.md
LIMIT_IRQ_MONITOR -- requirements
Module: limit_irq_monitor

Interface
REQ-001 Parameter CHN, default 2: number of monitored channels.
REQ-002 Parameter TRIP_CNT, default 3: consecutive over-limit samples required to trip, range 1..15.
REQ-003 Parameter CLR_CNT, default 3: consecutive recovered samples required to release, range 1..15.
REQ-004 Parameter HYST, default 4: 8-bit hysteresis below the threshold.
REQ-005 Parameter STALE_CYC, default 100_000_000: clk cycles without an update before a channel is flagged stale.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 value  input  CHN*8  per-channel sample; channel i occupies bits [i*8+:8].
REQ-009 value_update  input  CHN  one-cycle pulse per channel; value[i*8+:8] is valid in the same cycle.
REQ-010 threshold  input  CHN*8  per-channel limit, quasi-static.
REQ-011 irq_mask  input  CHN  1 = channel excluded from irq.
REQ-012 irq_clr  input  CHN  one-cycle write-1-to-clear pulse for irq_status.
REQ-013 over_limit  output  CHN  debounced over-limit level per channel.
REQ-014 irq_status  output  CHN  sticky trip flags.
REQ-015 stale  output  CHN  channel has not updated within STALE_CYC.
REQ-016 irq  output  1  registered interrupt request.

Function
REQ-017 Each channel SHALL run an independent FSM with states NORMAL, PEND, TRIPPED and RECOV, plus a 4-bit run counter.
REQ-018 The FSM and counter SHALL change only in cycles where value_update[i]=1; samples arriving in other cycles are ignored.
REQ-019 Over-limit test: sample > threshold, unsigned, strict; recovered test: sample <= threshold-HYST, saturating at 0; a threshold < HYST makes recovery require sample = 0.
REQ-020 NORMAL: an over sample enters PEND with count=1, or goes directly to TRIPPED if TRIP_CNT=1.
REQ-021 PEND: an over sample increments count, reaching TRIPPED when count = TRIP_CNT; a non-over sample returns to NORMAL with count=0.
REQ-022 TRIPPED: a recovered sample enters RECOV with count=1, or goes directly to NORMAL if CLR_CNT=1; any other sample stays in TRIPPED.
REQ-023 RECOV: a recovered sample increments count, reaching NORMAL when count = CLR_CNT; a non-recovered sample returns to TRIPPED with count=0.
REQ-024 over_limit[i] SHALL be 1 in TRIPPED and RECOV; it is registered and updates on the edge after the qualifying value_update.
REQ-025 irq_status[i] SHALL set on the same edge the FSM enters TRIPPED, and clear on irq_clr[i].
REQ-026 If a set and irq_clr[i] occur in the same cycle, the set SHALL win.
REQ-027 irq_status SHALL not re-set while the channel remains in TRIPPED or RECOV; a new trip requires passing through NORMAL.
REQ-028 irq SHALL be registered as OR(irq_status & ~irq_mask), one cycle after irq_status changes; a mask change takes effect after 1 cycle.
REQ-029 irq_mask SHALL not affect the FSM or irq_status.
REQ-030 Each channel's run counter SHALL not exceed 15.

Reset
REQ-031 While rst_n=0, all FSMs SHALL be in NORMAL and all counters, over_limit, irq_status, stale and irq SHALL be 0.
REQ-032 A reset asserted mid-debounce SHALL discard partial counts, with no residual trip after release.
REQ-033 The first value_update after rst_n rises SHALL be processed normally.

Configuration
REQ-034 Macro LIMIT_STALE_WDT_EN defined: each channel has a cycle counter, cleared on value_update[i].
REQ-035 Stale behaviour with the macro: stale[i] sets when the counter reaches STALE_CYC, holds and saturates, and clears on the edge after the next value_update[i].
REQ-036 Stale channels with the macro: a stale channel also sets irq_status[i], with one set per stale episode.
REQ-037 Macro not defined: there are no watchdog counters, stale is tied to 0, and trip logic is unchanged.

Verification
REQ-038 TRIP_CNT=3, threshold=0x50, updates 0x51,0x51,0x51 -> over_limit and irq_status rise 1 clk after the 3rd update; irq follows 1 clk later.
REQ-039 Updates 0x51,0x51,0x50,0x51 -> no trip; the count restarts after the 0x50 sample.
REQ-040 Tripped, HYST=4: updates 0x4D x3 -> over_limit stays 1; updates 0x4C x3 -> over_limit drops 1 clk after the 3rd.
REQ-041 irq_clr[0] in the same cycle as a ch0 trip -> irq_status[0]=1; irq_mask[0]=1 -> irq=0 while irq_status[0]=1.
REQ-042 Drop rst_n during PEND count=2, release, then one 0x51 update -> no trip, and count=1.
REQ-043 LIMIT_STALE_WDT_EN defined, STALE_CYC=1000, ch1 is never updated -> stale[1]=1 and irq_status[1]=1 at cycle 1000; one update clears stale[1].
